order_tx_arbiter: RTL and testbench
===================================

Name: order_tx_arbiter

Overview:
- N-channel successor to the single-source TX path. Collects order records (addr, buy/sell, timestamp) from NUM_CH trading-system instances and serialises them into the single UART transmitter.
- Each channel has a small record FIFO. A round-robin arbiter grants one record at a time and handshakes with the UART via tx_dv/tx_busy.
- Sits between the system instances and the uart block's TX interface.

Parameters:
- NUM_CH, 4: number of system channels (2..16).
- DEPTH, 4: records per channel FIFO; power of two, at least 2.
- TS_W, 32: timestamp width.
- BUSY_TIMEOUT, 16: cycles to wait for tx_busy to rise after tx_dv before abandoning the wait.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_addr  in  NUM_CH*8  per-channel record address; channel k occupies bits [8k+7:8k].
- in_buysell  in  NUM_CH*8  per-channel buy/sell code.
- in_timestamp  in  NUM_CH*TS_W  per-channel timestamp.
- in_dv  in  NUM_CH  per-channel single-cycle record-valid strobe.
- ovf  out  NUM_CH  sticky per-channel overflow flag.
- ovf_clr  in  NUM_CH  per-channel overflow clear strobe.
- tx_addr  out  8  record address to the UART.
- tx_buysell  out  8  buy/sell code to the UART.
- tx_timestamp  out  TS_W  timestamp to the UART.
- tx_dv  out  1  one-cycle start strobe to the UART.
- tx_busy  in  1  UART transmitting.
- grant_ch  out  max(1,$clog2(NUM_CH))  channel of the record currently being sent.

Behaviour:
- Reset (async, active-high) clears all of the following; nothing leaves reset until the reset input deasserts:
  - outputs tx_addr, tx_buysell, tx_timestamp, tx_dv, grant_ch, ovf;
  - all FIFO pointers and counts;
  - round-robin pointer rr = 0;
  - state = IDLE; timeout counter = 0.
- FIFO write:
  - in_dv[k] writes the channel k record into FIFO k when count_k < DEPTH.
  - The full test uses the pre-edge count. A write arriving on the same edge as a pop of a full FIFO is dropped.
  - A dropped write sets ovf[k].
  - ovf_clr[k] clears ovf[k]. If a set and a clear for the same channel occur on the same edge, the set wins.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any FIFO is non-empty, select the winner.
  - Winner = first non-empty channel searching from rr upward, with wrap-around.
  - On that edge: pop the winner's FIFO; register its record onto tx_* outputs; set grant_ch = winner; set tx_dv = 1 for exactly one cycle; set rr = winner+1 mod NUM_CH; go to WAIT_BUSY.
  - If tx_busy=1 while in IDLE, stay in IDLE and issue nothing.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT, return to IDLE; the record is considered consumed and not resent.
- WAIT_DONE: when tx_busy=0, return to IDLE and clear the timeout counter.
- Data hold: tx_addr, tx_buysell, tx_timestamp and grant_ch hold their values until the next grant.
- Latency: a record strobed at edge t into an empty system with an idle UART produces tx_dv high in the cycle after edge t+1. Back-to-back records are separated by at least the UART busy period plus 1 cycle.
- Simultaneous in_dv on several channels is legal; each channel is written independently.
- Reset mid-transfer abandons the transfer. tx_dv drops immediately and all FIFO contents are lost.

Optional Feature:
- Macro: TXARB_PRIO0_EN.
- Defined: channel 0 has strict priority. If FIFO 0 is non-empty in IDLE, it wins regardless of rr, and rr is not updated by channel-0 grants. The remaining channels round-robin among themselves.
- Undefined: pure round-robin over all channels, as described above.

Decomposition:
- Shared package hft_pkg holds:
  - ADDR_W=8, BS_W=8;
  - a record struct type {addr, buysell, timestamp};
  - the FSM state enum;
  - the default TS_W.
- One sub-module, rec_fifo: a single-channel synchronous FIFO with push, pop, full, empty, count and a push_drop output. It is instantiated NUM_CH times by a generate loop.
- The arbiter and FSM stay in the top module.

Test Plan:
- Single record: ch2 sends addr=0x02, bs=0x01, ts=0x0000_1234 with tx_busy held low. Expect tx_dv high for 1 cycle, one edge after the write edge; tx_* equal the record; grant_ch=2. The bench raises tx_busy for 10 cycles; the FSM returns to IDLE.
- Round-robin fairness: load 2 records each into ch0..ch3 at once. Grants must follow 0,1,2,3,0,1,2,3. No tx_dv is issued while tx_busy=1.
- Overflow: push 5 records into ch1 (DEPTH=4) while tx_busy is held at 1. Expect ovf[1]=1 and exactly 4 records later sent, in FIFO order. Pulse ovf_clr[1] and expect ovf[1]=0.
- Timeout: the UART never raises tx_busy after tx_dv. The FSM returns to IDLE after 16 cycles and sends the next queued record.
- Reset mid-operation: assert reset during WAIT_DONE with 3 records queued. All outputs must be 0 asynchronously; after release, no tx_dv occurs until new in_dv.
- TXARB_PRIO0_EN: with ch3 queued and ch0 receiving a record each grant slot, ch0 is always granted first. With the macro off, ch3 is granted at least every 2nd slot.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types for the order TX path: field widths, record layout and the arbiter FSM states.
package hft_pkg;

   localparam int ADDR_W   = 8;
   localparam int BS_W     = 8;
   localparam int TS_W_DEF = 32;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [BS_W-1:0]     buysell;
      logic [TS_W_DEF-1:0] timestamp;
   } rec_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/order_tx_arbiter_rec_fifo.sv
// Single-channel show-ahead record FIFO. Full is judged on the count before the edge, so a push
// that meets a pop of a full FIFO is still refused and flagged on push_drop.
module rec_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             push_drop
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign push_drop = push & full;
   assign dout      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/order_tx_arbiter.sv
// Collects order records from NUM_CH channels and serialises them into one UART transmitter.
// Define TXARB_PRIO0_EN to give channel 0 strict priority over the round-robin channels.
module order_tx_arbiter
   import hft_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DEPTH        = 4,
   parameter int TS_W         = TS_W_DEF,
   parameter int BUSY_TIMEOUT = 16,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH*8-1:0]    in_addr,
   input  logic [NUM_CH*8-1:0]    in_buysell,
   input  logic [NUM_CH*TS_W-1:0] in_timestamp,
   input  logic [NUM_CH-1:0]      in_dv,
   output logic [NUM_CH-1:0]      ovf,
   input  logic [NUM_CH-1:0]      ovf_clr,
   output logic [7:0]             tx_addr,
   output logic [7:0]             tx_buysell,
   output logic [TS_W-1:0]        tx_timestamp,
   output logic                   tx_dv,
   input  logic                   tx_busy,
   output logic [CH_W-1:0]        grant_ch
);

   localparam int REC_W = ADDR_W + BS_W + TS_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BS_W-1:0]   buysell;
      logic [TS_W-1:0]   timestamp;
   } chan_rec_t;

   logic [REC_W-1:0] dout [NUM_CH];
   logic [CNT_W-1:0] cnt  [NUM_CH];
   logic [NUM_CH-1:0] full, empty, drop, pop;

   state_t          state;
   logic [CH_W-1:0] rr, win, rr_next;
   logic [TO_W-1:0] tcnt;
   logic            found, grant;
   int              idx;
   chan_rec_t       win_rec;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      rec_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (in_dv[g]),
         .pop       (pop[g]),
         .din       ({in_addr[8*g +: 8], in_buysell[8*g +: 8], in_timestamp[TS_W*g +: TS_W]}),
         .dout      (dout[g]),
         .full      (full[g]),
         .empty     (empty[g]),
         .count     (cnt[g]),
         .push_drop (drop[g])
      );

      always_comb assert (reset || (cnt[g] <= CNT_W'(DEPTH) && !(full[g] && empty[g])));
   end

   // First non-empty channel at or after rr, wrapping; channel 0 may pre-empt the search.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(rr) + i) % NUM_CH;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            win   = CH_W'(idx);
         end
      end
`ifdef TXARB_PRIO0_EN
      if (!empty[0]) begin
         found = 1'b1;
         win   = '0;
      end
`endif
   end

   assign grant   = (state == IDLE) && !tx_busy && found;
   assign rr_next = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
   assign win_rec = dout[win];

   always_comb begin
      pop = '0;
      if (grant) pop[win] = 1'b1;
   end

   // UART handshake: tx_dv is a one-cycle start strobe with the record already stable on tx_*;
   // the UART acknowledges by raising tx_busy and finishes by dropping it. A missing
   // acknowledgement within BUSY_TIMEOUT cycles discards the record.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rr           <= '0;
         tcnt         <= '0;
         tx_dv        <= 1'b0;
         tx_addr      <= '0;
         tx_buysell   <= '0;
         tx_timestamp <= '0;
         grant_ch     <= '0;
      end else begin
         tx_dv <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  tx_addr      <= win_rec.addr;
                  tx_buysell   <= win_rec.buysell;
                  tx_timestamp <= win_rec.timestamp;
                  grant_ch     <= win;
                  tx_dv        <= 1'b1;
                  tcnt         <= '0;
                  state        <= WAIT_BUSY;
`ifdef TXARB_PRIO0_EN
                  if (win != '0) rr <= rr_next;
`else
                  rr <= rr_next;
`endif
               end
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (tcnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                  tcnt  <= '0;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  tcnt  <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf <= '0;
      else       ovf <= (ovf & ~ovf_clr) | drop;
   end

endmodule

// File: tb/tb_order_tx_arbiter.sv
// Self-checking bench for order_tx_arbiter with a simple UART busy model and transfer log.
module tb_order_tx_arbiter;
   import hft_pkg::*;

   localparam int NUM_CH = 4;
   localparam int DEPTH = 4;
   localparam int TS_W = 32;
   localparam int BUSY_TIMEOUT = 16;
   localparam int CH_W = 2;

   logic clk = 1'b0;
   logic reset;
   logic [NUM_CH*8-1:0] in_addr, in_buysell;
   logic [NUM_CH*TS_W-1:0] in_timestamp;
   logic [NUM_CH-1:0] in_dv, ovf, ovf_clr;
   logic [7:0] tx_addr, tx_buysell;
   logic [TS_W-1:0] tx_timestamp;
   logic tx_dv, tx_busy;
   logic [CH_W-1:0] grant_ch;

   always #5 clk = ~clk;

   order_tx_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_addr(in_addr), .in_buysell(in_buysell),
      .in_timestamp(in_timestamp), .in_dv(in_dv), .ovf(ovf), .ovf_clr(ovf_clr),
      .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp),
      .tx_dv(tx_dv), .tx_busy(tx_busy), .grant_ch(grant_ch)
   );

   typedef struct {
      int   ch;
      rec_t rec;
      int   cyc;
   } ev_t;

   typedef struct {
      int          ch;
      logic [7:0]  addr;
      logic [7:0]  bs;
      logic [31:0] ts;
      int          exp_ch;
      int          exp_lat;
   } vec_t;

   int checks = 0;
   int errors = 0;
   ev_t log_q[$];
   logic [7:0] exp_q[$];
   int exp_ch_q[$];

   bit uart_auto, busy_force, uart_flush, busy_pre;
   int uart_len, busy_cnt, cyc, busy_viol;

   // UART model and transfer monitor
   initial begin
      ev_t ev;
      tx_busy = 1'b0; busy_cnt = 0; cyc = 0; busy_viol = 0;
      forever begin
         @(posedge clk);
         cyc++;
         busy_pre = tx_busy;
         #1;
         if (uart_flush) busy_cnt = 0;
         if (busy_force) tx_busy = 1'b1;
         else if (busy_cnt > 0) begin tx_busy = 1'b1; busy_cnt--; end
         else tx_busy = 1'b0;
         @(negedge clk);
         if (tx_dv === 1'b1) begin
            if (busy_pre) busy_viol++;
            ev.ch = int'(grant_ch);
            ev.rec.addr = tx_addr;
            ev.rec.buysell = tx_buysell;
            ev.rec.timestamp = tx_timestamp;
            ev.cyc = cyc;
            log_q.push_back(ev);
            if (uart_auto) busy_cnt = uart_len;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_rec(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [31:0] t);
      in_addr[ch*8 +: 8] = a;
      in_buysell[ch*8 +: 8] = b;
      in_timestamp[ch*TS_W +: TS_W] = t;
   endtask

   task automatic strobe(input logic [NUM_CH-1:0] m, input logic [NUM_CH-1:0] clr);
      @(posedge clk); #2;
      in_dv = m; ovf_clr = clr;
      @(posedge clk); #2;
      in_dv = '0; ovf_clr = '0;
   endtask

   task automatic push(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [31:0] t);
      logic [NUM_CH-1:0] m;
      m = '0; m[ch] = 1'b1;
      set_rec(ch, a, b, t);
      strobe(m, '0);
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (log_q.size() < n && k < budget) begin @(posedge clk); k++; end
      #2;
      if (log_q.size() < n) begin
         checks++; errors++;
         $display("FAIL %s: wait expired, %0d transfers seen, %0d required", name, log_q.size(), n);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1; in_dv = '0; ovf_clr = '0; busy_force = 1'b0; uart_flush = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0; uart_flush = 1'b0;
      tick(1);
   endtask

   initial begin
      vec_t vecs[4];
      int   base, lat, exp_ch_list[7];
      bit   seen;
      ev_t  e0, e1;

      reset = 1'b1; in_dv = '0; ovf_clr = '0; in_addr = '0; in_buysell = '0; in_timestamp = '0;
      uart_auto = 1'b0; busy_force = 1'b0; uart_flush = 1'b1; uart_len = 10;
      #1;
      check("rst_tx_dv", tx_dv, 0);
      check("rst_grant", grant_ch, 0);
      check("rst_addr", tx_addr, 0);
      check("rst_ts", tx_timestamp, 0);
      check("rst_ovf", ovf, 0);
      do_reset();

      // Single records, table driven
      vecs[0] = '{2, 8'h02, 8'h01, 32'h0000_1234, 2, 2};
      vecs[1] = '{0, 8'hA5, 8'h02, 32'hDEAD_BEEF, 0, 2};
      vecs[2] = '{3, 8'hFF, 8'h80, 32'hFFFF_FFFF, 3, 2};
      vecs[3] = '{1, 8'h3C, 8'h01, 32'h0000_0001, 1, 2};
      uart_auto = 1'b1; uart_len = 10;
      for (int i = 0; i < 4; i++) begin
         set_rec(vecs[i].ch, vecs[i].addr, vecs[i].bs, vecs[i].ts);
         @(posedge clk); #2;
         in_dv[vecs[i].ch] = 1'b1;
         @(posedge clk); #2;
         in_dv = '0;
         lat = 0; seen = 1'b0;
         while (!seen && lat < 40) begin
            @(negedge clk); lat++;
            if (tx_dv === 1'b1) seen = 1'b1;
         end
         check("single_dv_seen", seen, 1);
         check("single_latency", lat, vecs[i].exp_lat);
         check("single_grant", grant_ch, vecs[i].exp_ch);
         check("single_addr", tx_addr, vecs[i].addr);
         check("single_bs", tx_buysell, vecs[i].bs);
         check("single_ts", tx_timestamp, vecs[i].ts);
         @(negedge clk);
         check("single_dv_width", tx_dv, 0);
         tick(14);
         check("single_hold", {grant_ch, tx_addr}, {2'(vecs[i].exp_ch), vecs[i].addr});
      end

      // Round-robin fairness
      do_reset();
      uart_auto = 1'b1; uart_len = 10;
      base = log_q.size();
      for (int c = 0; c < 4; c++) set_rec(c, 8'(c*16), 8'h01, 32'(c));
      strobe(4'hF, '0);
      for (int c = 0; c < 4; c++) set_rec(c, 8'(c*16 + 1), 8'h02, 32'(c + 16));
      strobe(4'hF, '0);
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 4; c++) begin exp_q.push_back(8'(c*16 + s)); exp_ch_q.push_back(c); end
      wait_log(base + 8, 300, "rr_wait");
      for (int i = 0; i < 8; i++) begin
         check("rr_ch", log_q[base+i].ch, exp_ch_q.pop_front());
         check("rr_addr", log_q[base+i].rec.addr, exp_q.pop_front());
      end
      check("rr_no_dv_while_busy", busy_viol, 0);

      // Overflow: fifth push into a full FIFO is dropped
      do_reset();
      uart_auto = 1'b1; uart_len = 4; busy_force = 1'b1;
      tick(2);
      base = log_q.size();
      for (int j = 0; j < 5; j++) push(1, 8'h40 + 8'(j), 8'h10 + 8'(j), 32'h100 + 32'(j));
      tick(1);
      check("ovf_set", ovf, 4'b0010);
      busy_force = 1'b0;
      for (int j = 0; j < 4; j++) exp_q.push_back(8'h40 + 8'(j));
      wait_log(base + 4, 200, "ovf_wait");
      for (int j = 0; j < 4; j++) begin
         check("ovf_ch", log_q[base+j].ch, 1);
         check("ovf_order", log_q[base+j].rec.addr, exp_q.pop_front());
      end
      tick(40);
      check("ovf_count_sent", log_q.size() - base, 4);
      check("ovf_sticky", ovf, 4'b0010);
      strobe('0, 4'b0010);
      check("ovf_clr", ovf, 4'b0000);

      // Write on the same edge as a pop of a full FIFO is dropped
      busy_force = 1'b1;
      tick(2);
      base = log_q.size();
      for (int j = 0; j < 4; j++) push(1, 8'h50 + 8'(j), 8'h20, 32'h200 + 32'(j));
      tick(1);
      check("popedge_full_no_ovf", ovf, 4'b0000);
      busy_force = 1'b0;
      set_rec(1, 8'h54, 8'h20, 32'h204);
      strobe(4'b0010, '0);
      check("popedge_ovf", ovf, 4'b0010);
      for (int j = 0; j < 4; j++) exp_q.push_back(8'h50 + 8'(j));
      wait_log(base + 4, 200, "popedge_wait");
      for (int j = 0; j < 4; j++) check("popedge_order", log_q[base+j].rec.addr, exp_q.pop_front());
      tick(40);
      check("popedge_count_sent", log_q.size() - base, 4);

      // Overflow set beats a same-edge clear
      strobe('0, 4'b0010);
      busy_force = 1'b1;
      tick(2);
      base = log_q.size();
      for (int j = 0; j < 4; j++) push(2, 8'h60 + 8'(j), 8'h30, 32'h300);
      set_rec(2, 8'h64, 8'h30, 32'h300);
      strobe(4'b0100, 4'b0100);
      check("ovf_set_wins", ovf, 4'b0100);
      busy_force = 1'b0;
      wait_log(base + 4, 200, "setwins_wait");
      tick(20);

      // Busy timeout: UART never acknowledges
      do_reset();
      uart_auto = 1'b0;
      base = log_q.size();
      set_rec(0, 8'h70, 8'h01, 32'h700);
      set_rec(1, 8'h71, 8'h02, 32'h701);
      strobe(4'b0011, '0);
      wait_log(base + 2, 100, "timeout_wait");
      e0 = log_q[base]; e1 = log_q[base+1];
      check("timeout_first", {8'(e0.ch), e0.rec.addr}, {8'd0, 8'h70});
      check("timeout_second", {8'(e1.ch), e1.rec.addr}, {8'd1, 8'h71});
      check("timeout_gap", e1.cyc - e0.cyc, BUSY_TIMEOUT + 1);
      tick(60);
      check("timeout_no_resend", log_q.size() - base, 2);

      // Reset during WAIT_DONE with three records still queued
      do_reset();
      uart_auto = 1'b1; uart_len = 20;
      base = log_q.size();
      for (int c = 0; c < 4; c++) set_rec(c, 8'h80 + 8'(c), 8'h05, 32'hABCD_0000 + 32'(c));
      strobe(4'hF, '0);
      wait_log(base + 1, 20, "rstmid_wait");
      tick(5);
      check("rstmid_pre_addr", tx_addr, 8'h80);
      #1;
      reset = 1'b1;
      #1;
      check("rstmid_dv", tx_dv, 0);
      check("rstmid_addr", tx_addr, 0);
      check("rstmid_bs", tx_buysell, 0);
      check("rstmid_ts", tx_timestamp, 0);
      check("rstmid_grant", grant_ch, 0);
      check("rstmid_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      tick(60);
      check("rstmid_no_dv", log_q.size() - base, 1);
      push(2, 8'h99, 8'h09, 32'h9999);
      wait_log(base + 2, 60, "rstmid_new_wait");
      check("rstmid_new", {8'(log_q[base+1].ch), log_q[base+1].rec.addr}, {8'd2, 8'h99});

      // Channel 0 refilled every grant slot while channel 3 waits
      do_reset();
      uart_auto = 1'b1; uart_len = 4; busy_force = 1'b1;
      tick(2);
      base = log_q.size();
      set_rec(3, 8'hC1, 8'h03, 32'h1); strobe(4'b1000, '0);
      set_rec(3, 8'hC2, 8'h03, 32'h2); strobe(4'b1000, '0);
      set_rec(0, 8'hA0, 8'h00, 32'h3); strobe(4'b0001, '0);
      busy_force = 1'b0;
      for (int s = 0; s < 4; s++) begin
         wait_log(base + s + 1, 60, "prio_slot_wait");
         push(0, 8'hA1 + 8'(s), 8'h00, 32'h10 + 32'(s));
      end
      wait_log(base + 7, 200, "prio_wait");
`ifdef TXARB_PRIO0_EN
      exp_ch_list = '{0, 0, 0, 0, 0, 3, 3};
`else
      exp_ch_list = '{0, 3, 0, 3, 0, 0, 0};
`endif
      for (int i = 0; i < 7; i++) check("prio_slot_ch", log_q[base+i].ch, exp_ch_list[i]);

      check("no_dv_while_busy", busy_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
